coin_acceptor: RTL and testbench

Front-end stage directly upstream of the vending machine controller. Conditions the raw coin-slot sensors: synchronise, debounce, classify, reject invalid insertions. Queues accepted coins and replays them as clean single-cycle five_rup / ten_rup pulses, spaced so the controller never sees two coins in one cycle or back-to-back.

---
 rtl/coin_acceptor_pkg.sv | 19 +
 rtl/coin_acceptor_debounce.sv | 46 ++++
 rtl/coin_acceptor.sv | 142 ++++++++++++++
 tb/tb_coin_acceptor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// Shared types and default constants for the coin acceptor front end.
package coin_pkg;

  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_FIFO_DEPTH      = 4;
  localparam int unsigned DEF_GAP_CYCLES      = 1;

endpackage

// File: rtl/coin_acceptor_debounce.sv
// One coin-slot channel: 2-flop synchroniser, debounce counter, and a
// single-cycle event on each debounced 0->1 transition.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic coin_event
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          settle;

  // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES.
  assign settle     = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign coin_event = settle && sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounces both sensors, classifies/rejects coins,
// queues accepted ones and replays them as spaced single-cycle pulses.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              coin5_raw,
  input  logic                              coin10_raw,
  input  logic                              accept_en,
  output logic                              five_rup,
  output logic                              ten_rup,
  output logic                              coin_reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_cnt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  logic ev5;
  logic ev10;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
    .clk        (clk),
    .rst        (rst),
    .raw        (coin5_raw),
    .coin_event (ev5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
    .clk        (clk),
    .rst        (rst),
    .raw        (coin10_raw),
    .coin_event (ev10)
  );

  logic             any_event;
  logic             fifo_full;
  logic             fifo_nonempty;
  logic             push;
  logic             pop;
  logic             reject;
  coin_t            push_code;
  coin_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign any_event     = ev5 || ev10;
  assign fifo_full     = (pending_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (pending_cnt != '0);
  assign push          = any_event && !(ev5 && ev10) && accept_en && !fifo_full;
  assign reject        = any_event && !push;
  assign push_code     = ev10 ? COIN_10 : COIN_5;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending_cnt <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= reject;
      if (push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   pending_cnt <= pending_cnt + CNT_W'(1);
        2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  state_t           state;
  state_t           next_state;
  coin_t            cur_code;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;

  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cur_code <= COIN_5;
      gap_cnt  <= '0;
    end else begin
      state   <= next_state;
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (pop) begin
        cur_code <= mem[rd_ptr];
      end
    end
  end

  // The final GAP cycle hands a waiting coin straight to PULSE, so queued
  // coins go out exactly GAP_CYCLES low cycles apart instead of gaining an
  // extra IDLE cycle each.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          next_state = PULSE;
        end
      end
      PULSE: next_state = GAP;
      GAP: begin
        if (gap_done) begin
          if (fifo_nonempty) begin
            pop        = 1'b1;
            next_state = PULSE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    five_rup = 1'b0;
    ten_rup  = 1'b0;
    if (state == PULSE) begin
      five_rup = (cur_code == COIN_5);
      ten_rup  = (cur_code == COIN_10);
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: two instances (default and fast-debounce/long-gap)
// driven with the same stimulus and checked every cycle against a timing model.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       accept_en = 1'b1;
  logic       five_a, ten_a, rej_a;
  logic       five_b, ten_b, rej_b;
  logic [2:0] pend_a, pend_b;

  always #5 clk = ~clk;

  coin_acceptor u_dut_a (
    .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .accept_en(accept_en), .five_rup(five_a), .ten_rup(ten_a),
    .coin_reject(rej_a), .pending_cnt(pend_a)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(1), .GAP_CYCLES(15)) u_dut_b (
    .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .accept_en(accept_en), .five_rup(five_b), .ten_rup(ten_b),
    .coin_reject(rej_b), .pending_cnt(pend_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  dcyc [2] = '{4, 1};
  int  gcyc [2] = '{1, 15};
  int  n = 0;
  bit  model_valid = 0;
  bit  sh1 [2], sh2 [2], last_s2 [2];
  int  chg [2];
  bit  st  [2][2];
  int  flp [2][2];
  bit  q0 [$];
  bit  q1 [$];
  int  next_pop [2];
  bit  e_five [2], e_ten [2], e_rej [2];
  int  e_pend [2];

  always @(posedge clk) begin
    bit raw [2];
    bit s2p [2];
    bit ev  [2];
    bit q [$];
    bit code;
    int a, sp;
    n++;
    if (!rst) begin
      model_valid = 1;
      q0.delete();
      q1.delete();
      for (int c = 0; c < 2; c++) begin
        sh1[c] = 0; sh2[c] = 0; last_s2[c] = 0; chg[c] = n;
      end
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 2; c++) begin
          st[i][c] = 0; flp[i][c] = n;
        end
        next_pop[i] = 0;
        e_five[i] = 0; e_ten[i] = 0; e_rej[i] = 0; e_pend[i] = 0;
      end
    end else begin
      raw[0] = coin5_raw;
      raw[1] = coin10_raw;
      for (int c = 0; c < 2; c++) begin
        s2p[c] = sh2[c];
        if (s2p[c] != last_s2[c]) chg[c] = n - 1;
        last_s2[c] = s2p[c];
      end
      for (int i = 0; i < 2; i++) begin
        // A level becomes stable once it has been seen for dcyc consecutive
        // edges since the later of its appearance and the previous flip.
        for (int c = 0; c < 2; c++) begin
          ev[c] = 0;
          a = (chg[c] > flp[i][c]) ? chg[c] : flp[i][c];
          if (s2p[c] != st[i][c] && n - a >= dcyc[i]) begin
            st[i][c]  = s2p[c];
            flp[i][c] = n;
            ev[c]     = s2p[c];
          end
        end
        if (i == 0) q = q0; else q = q1;
        sp = q.size();
        e_five[i] = 0; e_ten[i] = 0; e_rej[i] = 0;
        if (sp > 0 && n >= next_pop[i]) begin
          code = q.pop_front();
          e_five[i] = !code;
          e_ten[i]  = code;
          next_pop[i] = n + 1 + gcyc[i];
        end
        if (ev[0] || ev[1]) begin
          if ((ev[0] && ev[1]) || !accept_en || sp >= 4) e_rej[i] = 1;
          else q.push_back(ev[1]);
        end
        e_pend[i] = q.size();
        if (i == 0) q0 = q; else q1 = q;
      end
      for (int c = 0; c < 2; c++) begin
        sh2[c] = sh1[c];
        sh1[c] = raw[c];
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      chk("five_a", five_a, e_five[0]);
      chk("ten_a",  ten_a,  e_ten[0]);
      chk("rej_a",  rej_a,  e_rej[0]);
      chk("pend_a", pend_a, e_pend[0]);
      chk("five_b", five_b, e_five[1]);
      chk("ten_b",  ten_b,  e_ten[1]);
      chk("rej_b",  rej_b,  e_rej[1]);
      chk("pend_b", pend_b, e_pend[1]);
      chk("excl_a", five_a & ten_a, 0);
      chk("excl_b", five_b & ten_b, 0);
    end
  end

  // ---------------- pulse monitors for directed checks ----------------
  int cnt_five [2], cnt_ten [2], cnt_rej [2], max_pend [2];
  int first_five_a;
  int five_b_edges [$];

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_five[i] = 0; cnt_ten[i] = 0; cnt_rej[i] = 0; max_pend[i] = 0;
    end
    first_five_a = -1;
    five_b_edges.delete();
  endtask

  always @(negedge clk) begin
    cnt_five[0] += five_a; cnt_ten[0] += ten_a; cnt_rej[0] += rej_a;
    cnt_five[1] += five_b; cnt_ten[1] += ten_b; cnt_rej[1] += rej_b;
    if (pend_a > max_pend[0]) max_pend[0] = pend_a;
    if (pend_b > max_pend[1]) max_pend[1] = pend_b;
    if (five_a && first_five_a < 0) first_five_a = n;
    if (five_b) five_b_edges.push_back(n);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic coin5(input int hi, input int lo);
    coin5_raw = 1'b1;
    tick(hi);
    coin5_raw = 1'b0;
    tick(lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    bit found;
    accept_en = 1'b1;
    tick(1);
    do_reset();

    // Test 1: single 5-rupee coin, default instance latency
    clear_counts();
    chk("reset_pend_a", pend_a, 0);
    chk("reset_five_a", five_a, 0);
    e0 = n;
    coin5(10, 30);
    chk("t1_latency", first_five_a - e0, 7);
    chk("t1_five_cnt", cnt_five[0], 1);
    chk("t1_ten_cnt", cnt_ten[0], 0);
    chk("t1_rej_cnt", cnt_rej[0], 0);
    chk("t1_pend_end", pend_a, 0);

    // Test 2: bouncing 10-rupee sensor
    do_reset();
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      coin10_raw = (k % 2 == 0);
      tick(1);
    end
    coin10_raw = 1'b1;
    tick(8);
    coin10_raw = 1'b0;
    tick(30);
    chk("t2_ten_cnt", cnt_ten[0], 1);
    chk("t2_five_cnt", cnt_five[0], 0);
    chk("t2_rej_cnt", cnt_rej[0], 0);

    // Test 3: both sensors rise together
    do_reset();
    clear_counts();
    coin5_raw = 1'b1;
    coin10_raw = 1'b1;
    tick(8);
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    tick(30);
    chk("t3_rej_cnt", cnt_rej[0], 1);
    chk("t3_pulses", cnt_five[0] + cnt_ten[0], 0);
    chk("t3_max_pend", max_pend[0], 0);

    // Test 4: accept disabled, then re-enabled
    do_reset();
    clear_counts();
    accept_en = 1'b0;
    coin5(8, 20);
    chk("t4_rej_cnt", cnt_rej[0], 1);
    chk("t4_five_off", cnt_five[0], 0);
    accept_en = 1'b1;
    coin5(8, 30);
    chk("t4_five_on", cnt_five[0], 1);
    chk("t4_rej_total", cnt_rej[0], 1);

    // Test 5: overflow on the fast instance; coins 3 cycles apart so the
    // sixth arrives while four are still waiting behind the long gap
    do_reset();
    clear_counts();
    repeat (6) coin5(2, 1);
    tick(120);
    chk("t5_five_cnt", cnt_five[1], 5);
    chk("t5_rej_cnt", cnt_rej[1], 1);
    chk("t5_max_pend", max_pend[1], 4);
    chk("t5_pulse_log", five_b_edges.size(), 5);
    for (int k = 1; k < five_b_edges.size(); k++)
      chk("t5_spacing", five_b_edges[k] - five_b_edges[k-1], 16);

    // Test 6: reset while three coins wait and the FSM is in its gap
    do_reset();
    clear_counts();
    repeat (4) coin5(2, 1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (pend_b == 3) found = 1;
    end
    chk("t6_reach_pend3", found, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_pend", pend_b, 0);
    chk("t6_rst_five", five_b, 0);
    chk("t6_rst_ten", ten_b, 0);
    chk("t6_rst_rej", rej_b, 0);
    rst = 1'b1;
    clear_counts();
    tick(80);
    chk("t6_no_pulse_b", cnt_five[1] + cnt_ten[1], 0);
    chk("t6_no_pulse_a", cnt_five[0] + cnt_ten[0], 0);

    // Randomised phase: sensor levels, enable and occasional resets
    begin
      int hold5 = 0, hold10 = 0;
      for (int k = 0; k < 3000; k++) begin
        if (hold5 == 0) begin
          coin5_raw = $urandom_range(0, 1);
          hold5 = $urandom_range(1, 10);
        end
        if (hold10 == 0) begin
          coin10_raw = $urandom_range(0, 1);
          hold10 = $urandom_range(1, 10);
        end
        hold5--;
        hold10--;
        if ($urandom_range(0, 49) == 0) accept_en = ~accept_en;
        rst = ($urandom_range(0, 399) != 0);
        tick(1);
      end
      rst = 1'b1;
      coin5_raw = 1'b0;
      coin10_raw = 1'b0;
      tick(150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
